// File: rtl/pc_control_unit_if.sv
// Instruction/flag inputs and decode/PC outputs of the program-counter control unit.
// The master side issues instructions; the slave side is the control unit itself.
interface pc_control_unit_if #(
  parameter int D = 12
);
  logic [8:0]   mach_code;
  logic         flag_one;
  logic [D-1:0] prog_ctr;
  logic [D-1:0] target;
  logic [1:0]   inst_type;
  logic         branch_inst;
  logic         mem_read;
  logic         mem_write;
  logic         alu_src;
  logic         reg_write;
  logic         mem_to_reg;
  logic [3:0]   alu_op;
  logic         done;

  modport master (
    output mach_code, flag_one,
    input  prog_ctr, target, inst_type, branch_inst, mem_read, mem_write,
           alu_src, reg_write, mem_to_reg, alu_op, done
  );

  modport slave (
    input  mach_code, flag_one,
    output prog_ctr, target, inst_type, branch_inst, mem_read, mem_write,
           alu_src, reg_write, mem_to_reg, alu_op, done
  );
endinterface

// File: rtl/pc_control_unit.sv
// Program counter with zero-latency instruction decode, branch-target LUT and
// absolute/relative jump selection. The interface width must match D.
module pc_control_unit #(
  parameter int           D        = 12,
  parameter logic [D-1:0] DONE_PC  = 12'd5,
  parameter logic [16*D-1:0] LUT_INIT = {
    12'h0F0, 12'h0E0, 12'h0D0, 12'h0C0, 12'h0B0, 12'h0A0, 12'h090, 12'h080,
    12'h070, 12'h060, 12'h050, 12'h040, 12'h030, 12'h020, 12'h010, 12'h000
  }
) (
  input logic             clk,
  input logic             reset,
  pc_control_unit_if.slave bus
);

  logic [D-1:0] lut [0:15];
  logic [D-1:0] target_w;
  logic [D-1:0] prog_ctr_q;
  logic [D-1:0] prog_ctr_d;

  logic [4:0] opc;
  logic [1:0] inst_type_w;
  logic       branch_w;
  logic       mem_read_w;
  logic       mem_write_w;
  logic       alu_src_w;
  logic       reg_write_w;
  logic       mem_to_reg_w;
  logic [3:0] alu_op_w;
  logic       is_jrel;
  logic       jump_abs;

  for (genvar gi = 0; gi < 16; gi++) begin : g_lut
    assign lut[gi] = LUT_INIT[gi*D +: D];
  end

  assign opc      = bus.mach_code[8:4];
  assign target_w = lut[bus.mach_code[3:0]];

  always_comb begin
    inst_type_w  = 2'b00;
    branch_w     = 1'b0;
    mem_read_w   = 1'b0;
    mem_write_w  = 1'b0;
    alu_src_w    = 1'b0;
    reg_write_w  = 1'b0;
    mem_to_reg_w = 1'b0;
    alu_op_w     = 4'b0000;
    is_jrel      = 1'b0;
    case (opc[4:3])
      2'b00: begin
        inst_type_w  = 2'b10;
        mem_read_w   = 1'b1;
        mem_to_reg_w = 1'b1;
        reg_write_w  = 1'b1;
      end
      2'b01: begin
        inst_type_w = 2'b10;
        mem_write_w = 1'b1;
      end
      2'b10: begin
        reg_write_w = 1'b1;
        alu_src_w   = 1'b1;
        alu_op_w    = {1'b0, opc[2:0]};
      end
      default: begin
        // 111xx is NOP: everything stays at its default
        case (opc[2:0])
          3'b000: begin
            inst_type_w = 2'b01;
            reg_write_w = 1'b1;
          end
          3'b001: branch_w = 1'b1;
          3'b010: begin
            reg_write_w = 1'b1;
            alu_op_w    = 4'b1000;
          end
          3'b011: is_jrel = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  assign jump_abs = branch_w & bus.flag_one;

  always_comb begin
    prog_ctr_d = prog_ctr_q + D'(1);
    if (jump_abs) begin
      prog_ctr_d = target_w;
    end else if (is_jrel) begin
      prog_ctr_d = prog_ctr_q + target_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr_q <= '0;
    end else begin
      prog_ctr_q <= prog_ctr_d;
    end
  end

  assign bus.prog_ctr    = prog_ctr_q;
  assign bus.target      = target_w;
  assign bus.inst_type   = inst_type_w;
  assign bus.branch_inst = branch_w;
  assign bus.mem_read    = mem_read_w;
  assign bus.mem_write   = mem_write_w;
  assign bus.alu_src     = alu_src_w;
  assign bus.reg_write   = reg_write_w;
  assign bus.mem_to_reg  = mem_to_reg_w;
  assign bus.alu_op      = alu_op_w;
  assign bus.done        = (prog_ctr_q == DONE_PC);

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: decode table sweep plus PC sequences checked
// against a queue of expected program-counter values.
module tb_pc_control_unit;
  localparam int D = 12;

  logic clk;
  logic reset;

  pc_control_unit_if #(.D(D)) ifc ();

  pc_control_unit #(.D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] mc;
    logic [1:0] it;
    logic       br;
    logic       mr;
    logic       mw;
    logic       as;
    logic       rw;
    logic       m2r;
    logic [3:0] op;
  } dec_vec_t;

  dec_vec_t    vecs [32];
  logic [D-1:0] exp_q [$];
  logic [D-1:0] exp_pc;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [D-1:0] lut_val(input logic [3:0] idx);
    logic [D-1:0] v;
    v = '0;
    v[7:4] = idx;
    return v;
  endfunction

  // One clock: drive at negedge, predict next PC, compare after the edge.
  task automatic cycle(input logic [8:0] mc, input logic fl, input logic rs);
    logic [D-1:0] nxt;
    logic [D-1:0] got;
    logic [D-1:0] want;
    @(negedge clk);
    ifc.mach_code = mc;
    ifc.flag_one  = fl;
    reset         = rs;
    if (rs)                         nxt = '0;
    else if (mc[8:4] == 5'b11001 && fl) nxt = lut_val(mc[3:0]);
    else if (mc[8:4] == 5'b11011)   nxt = exp_pc + lut_val(mc[3:0]);
    else                            nxt = exp_pc + 12'd1;
    exp_q.push_back(nxt);
    exp_pc = nxt;
    @(posedge clk);
    #1;
    got  = ifc.prog_ctr;
    want = exp_q.pop_front();
    $display("cycle mc=%h flag=%0d rst=%0d pc=%h done=%0d", mc, fl, rs, got, ifc.done);
    chk("prog_ctr", 32'(got), 32'(want));
    chk("done", 32'(ifc.done), 32'(want == 12'd5));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_pc   = '0;
    reset    = 1'b1;
    ifc.mach_code = 9'h1C0;
    ifc.flag_one  = 1'b0;

    // Expected decode rows, one per opcode, with a varied LUT index.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] o;
      o = 5'(i);
      vecs[i].mc  = {o, 4'((i * 7) & 15)};
      vecs[i].it  = 2'b00; vecs[i].br = 1'b0; vecs[i].mr = 1'b0; vecs[i].mw = 1'b0;
      vecs[i].as  = 1'b0;  vecs[i].rw = 1'b0; vecs[i].m2r = 1'b0; vecs[i].op = 4'h0;
      if (o[4:3] == 2'b00) begin
        vecs[i].it = 2'b10; vecs[i].mr = 1'b1; vecs[i].m2r = 1'b1; vecs[i].rw = 1'b1;
      end else if (o[4:3] == 2'b01) begin
        vecs[i].it = 2'b10; vecs[i].mw = 1'b1;
      end else if (o[4:3] == 2'b10) begin
        vecs[i].rw = 1'b1; vecs[i].as = 1'b1; vecs[i].op = {1'b0, o[2:0]};
      end else if (o == 5'b11000) begin
        vecs[i].it = 2'b01; vecs[i].rw = 1'b1;
      end else if (o == 5'b11001) begin
        vecs[i].br = 1'b1;
      end else if (o == 5'b11010) begin
        vecs[i].rw = 1'b1; vecs[i].op = 4'b1000;
      end
    end

    // Reset edge: PC to zero, done low.
    cycle(9'h1C0, 1'b0, 1'b1);

    // Decode sweep while reset is held: outputs still follow mach_code.
    for (int i = 0; i < 32; i++) begin
      logic [11:0] got_v;
      logic [11:0] want_v;
      ifc.mach_code = vecs[i].mc;
      #1;
      got_v  = {ifc.inst_type, ifc.branch_inst, ifc.mem_read, ifc.mem_write,
                ifc.alu_src, ifc.reg_write, ifc.mem_to_reg, ifc.alu_op};
      want_v = {vecs[i].it, vecs[i].br, vecs[i].mr, vecs[i].mw,
                vecs[i].as, vecs[i].rw, vecs[i].m2r, vecs[i].op};
      $display("decode mc=%h strobes=%h target=%h", vecs[i].mc, got_v, ifc.target);
      chk($sformatf("decode_%0d", i), 32'(got_v), 32'(want_v));
      chk($sformatf("target_%0d", i), 32'(ifc.target), 32'(lut_val(vecs[i].mc[3:0])));
    end
    chk("prog_ctr_held_in_reset", 32'(ifc.prog_ctr), 32'h0);

    // NOP run from 0 through done at 5 and beyond.
    for (int i = 0; i < 6; i++) cycle(9'h1C0, 1'b0, 1'b0);

    // BR idx 3: taken with flag, otherwise +1.
    cycle(9'h193, 1'b1, 1'b0);
    cycle(9'h193, 1'b0, 1'b0);
    // JREL without flag is still taken; flag on non-branch ignored.
    cycle(9'h191, 1'b1, 1'b0);
    cycle(9'h1B2, 1'b0, 1'b0);
    cycle(9'h150, 1'b1, 1'b0);

    // Walk to 0xFF0 via 0x0F0 * 17, then relative wrap to 0x000.
    cycle(9'h19F, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(9'h1BF, 1'b0, 1'b0);
    cycle(9'h1B1, 1'b0, 1'b0);

    // Back to 0xFF0, step to 0xFFF, then increment wraps.
    cycle(9'h19F, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(9'h1BF, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(9'h1C0, 1'b0, 1'b0);

    // Reset overrides a taken branch.
    cycle(9'h193, 1'b1, 1'b0);
    cycle(9'h195, 1'b1, 1'b1);
    cycle(9'h1C0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_control_unit.md
PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

Interface
REQ-001 SHALL have parameter D, default 12, program counter width.
REQ-002 SHALL have parameter DONE_PC, default 12'd5, PC value that asserts done.
REQ-003 SHALL have parameter LUT_INIT, 16x D packed, default entry i = i*16; branch target table.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 mach_code  in  9  current instruction word.
REQ-007 flag_one  in  1  registered "one" ALU flag from previous cycle; branch condition.
REQ-008 prog_ctr  out  D  current program counter.
REQ-009 target  out  D  LUT target addressed by mach_code[3:0].
REQ-010 inst_type  out  2  bit1 = I-type register fields, bit0 = immediate write data (movi).
REQ-011 branch_inst, mem_read, mem_write, alu_src, reg_write, mem_to_reg  out  1 each  control strobes.
REQ-012 alu_op  out  4  ALU command.
REQ-013 done  out  1  high while prog_ctr == DONE_PC.

Function
REQ-014 Decode SHALL be purely combinational from mach_code[8:4]; zero-latency.
REQ-015 Unlisted outputs SHALL be 0 in every decode row below.
REQ-016 [8:7]=00 LB: inst_type=10, mem_read=1, mem_to_reg=1, reg_write=1, alu_src=0, alu_op=0000.
REQ-017 [8:7]=01 SB: inst_type=10, mem_write=1, alu_src=0, alu_op=0000.
REQ-018 [8:7]=10 R-type: inst_type=00, reg_write=1, alu_src=1, alu_op={0,mach_code[6:4]}.
REQ-019 [8:4]=11000 MOVI: inst_type=01, reg_write=1.
REQ-020 [8:4]=11001 BR: branch_inst=1 (conditional absolute jump to target).
REQ-021 [8:4]=11010 ADDI: inst_type=00, reg_write=1, alu_src=0, alu_op=1000.
REQ-022 [8:4]=11011 JREL: unconditional relative jump; no strobes asserted.
REQ-023 [8:4]=111xx NOP: all outputs 0, alu_op=0000.
REQ-024 target SHALL equal LUT_INIT entry mach_code[3:0], combinational, for every opcode.
REQ-025 Absolute jump enable SHALL be branch_inst AND flag_one.
REQ-026 Next PC priority: reset -> 0; else absolute jump -> target; else JREL -> prog_ctr + target; else prog_ctr + 1.
REQ-027 All PC arithmetic SHALL be modulo 2^D; 0xFFF + 1 wraps to 0x000; relative sum wraps likewise.
REQ-028 BR with flag_one=0 SHALL advance by 1.
REQ-029 done SHALL be combinational from prog_ctr; PC keeps running after done (no halt).

Reset
REQ-030 Synchronous reset SHALL load prog_ctr=0 on the next rising edge, overriding any jump in the same cycle.
REQ-031 Decode outputs and target have no reset; they follow mach_code at all times, including during reset.
REQ-032 done SHALL be 0 after reset unless DONE_PC=0.

Verification
REQ-033 reset=1 one edge, then 6 edges of NOP (mach_code=9'h1C0) -> prog_ctr 0,1,2,3,4,5; done=1 exactly at 5.
REQ-034 mach_code=9'h193 (BR, idx 3), flag_one=1 -> next prog_ctr=12'h030; flag_one=0 -> prog_ctr+1.
REQ-035 prog_ctr=12'h010, mach_code=9'h1B2 (JREL, idx 2, target 12'h020) -> next prog_ctr=12'h030; prog_ctr=12'hFF0, idx 1 -> 12'h000.
REQ-036 Sweep all 32 values of mach_code[8:4] -> strobes/alu_op match REQ-016..023 (e.g. 9'h150 R-type: alu_op=0101, alu_src=1, reg_write=1).
REQ-037 prog_ctr=12'hFFF with NOP -> 12'h000; reset asserted with BR and flag_one=1 -> 12'h000.
